// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// No datapath latency; no flow control (pure constants and helpers).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    RELEASE  = 3'd3,
    RUN      = 3'd4,
    FAIL     = 3'd5
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 32;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 270000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2700;
  localparam int unsigned DEF_DSP_RST_HOLD        = 16;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous level signal.
// Latency STAGES cycles; no flow control.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises rPLL reset/lock and sequences DSP reset release with bounded relock retries.
// Outputs decode the state register; lock sampled through a SYNC_STAGES synchronizer; no flow control.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned DSP_RST_HOLD        = DEF_DSP_RST_HOLD,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       dsp_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES, DSP_RST_HOLD);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DSP_RST_HOLD - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pll_lock),
    .dout  (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLLRST;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    // A relock request outranks both lock loss and timeout in the same cycle.
    if (relock_req && state_q != PLLRST) begin
      state_d = PLLRST;
      if (state_q == FAIL) retry_d = '0;
    end else begin
      case (state_q)
        PLLRST:   if (cnt_q == RST_LAST) state_d = WAITLOCK;
        WAITLOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 3'd1;
              state_d = PLLRST;
            end else begin
              state_d = FAIL;
            end
          end
        end
        STABLE: begin
          if (!lock_s)                state_d = WAITLOCK;
          else if (cnt_q == STB_LAST) state_d = RELEASE;
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = PLLRST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = PLLRST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = PLLRST;
      endcase
    end
    // RUN and FAIL have no timed exit, so their counter simply holds.
    if (state_d != state_q)                    cnt_d = '0;
    else if (state_q != RUN && state_q != FAIL) cnt_d = cnt_q + 1'b1;
  end

  assign pll_reset     = (state_q == PLLRST) || (state_q == FAIL);
  assign dsp_reset     = (state_q != RUN);
  assign ready         = (state_q == RUN);
  assign fail          = (state_q == FAIL);
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/relock/reset traffic
// checked cycle-by-cycle against a countdown-style behavioural model.
module tb_pll_reset_sequencer;

  localparam int PRST = 4, TMO = 64, STB = 8, HOLD = 4, MAXR = 2, SYNC = 2;
  localparam int UP   = PRST + 1 + STB + HOLD;

  logic       clk = 1'b0;
  logic       reset = 1'b1, pll_lock = 1'b0, relock_req = 1'b0;
  logic       pll_reset, dsp_reset, ready, fail;
  logic [2:0] retry_cnt, state;
  logic [7:0] lock_loss_cnt;

  int checks = 0, errors = 0;
  int exp_loss = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT_CYCLES(TMO), .LOCK_STABLE_CYCLES(STB),
    .DSP_RST_HOLD(HOLD), .MAX_RETRIES(MAXR), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .dsp_reset(dsp_reset), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  // Reference model: phase number plus cycles left in that phase.
  int m_st = 0, m_left = PRST, m_retry = 0, m_loss = 0;
  bit m_hist[SYNC];

  function automatic int dur(int s);
    case (s)
      0: return PRST;
      1: return TMO;
      2: return STB;
      3: return HOLD;
      default: return 0;
    endcase
  endfunction

  function automatic void m_enter(int s);
    m_st   = s;
    m_left = dur(s);
  endfunction

  function automatic void m_lost();
    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
    m_enter(0);
  endfunction

  function automatic void model_step(bit r, bit rq, bit pl);
    bit ls;
    if (r) begin
      m_enter(0);
      m_retry = 0;
      m_loss  = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
      return;
    end
    ls = m_hist[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pl;
    if (rq && m_st != 0) begin
      if (m_st == 5) m_retry = 0;
      m_enter(0);
      return;
    end
    case (m_st)
      0: begin m_left--; if (m_left == 0) m_enter(1); end
      1: begin
        if (ls) m_enter(2);
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retry < MAXR) begin m_retry++; m_enter(0); end
            else m_enter(5);
          end
        end
      end
      2: begin
        if (!ls) m_enter(1);
        else begin m_left--; if (m_left == 0) m_enter(3); end
      end
      3: begin
        if (!ls) m_lost();
        else begin m_left--; if (m_left == 0) begin m_retry = 0; m_enter(4); end end
      end
      4: if (!ls) m_lost();
      default: ;
    endcase
  endfunction

  task automatic tick();
    bit r = reset, rq = relock_req, pl = pll_lock;
    @(posedge clk);
    model_step(r, rq, pl);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b1; relock_req = 1'b0;
    tick(); tick();
    checks++;
    if ({state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt} !==
        {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: state=%0d pr=%b dr=%b rdy=%b fail=%b retry=%0d loss=%0d",
               state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt);
    end
  endtask

  task automatic test_startup();
    reset = 1'b0;
    for (int e = 1; e <= UP + 3; e++) begin
      tick();
      checks++;
      if (pll_reset !== (e < PRST)) begin
        errors++;
        $display("FAIL startup_pll_reset edge %0d: got %b want %b", e, pll_reset, e < PRST);
      end
      checks++;
      if (ready !== (e >= UP) || dsp_reset !== (e < UP)) begin
        errors++;
        $display("FAIL startup_ready edge %0d: ready=%b dsp_reset=%b want ready=%b", e, ready, dsp_reset, e >= UP);
      end
    end
  endtask

  task automatic test_lock_loss();
    int n = 0;
    pll_lock = 1'b0; tick();
    pll_lock = 1'b1; tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL loss_early: ready=%b want 1 two edges after drop", ready); end
    tick();
    exp_loss++;
    checks++;
    if (ready !== 1'b0 || dsp_reset !== 1'b1 || state !== 3'd0 || lock_loss_cnt !== 8'(exp_loss)) begin
      errors++;
      $display("FAIL loss_react: ready=%b dsp_reset=%b state=%0d loss=%0d want 0/1/0/%0d",
               ready, dsp_reset, state, lock_loss_cnt, exp_loss);
    end
    while (!ready && n < 200) begin tick(); n++; end
    checks++;
    if (n !== UP) begin errors++; $display("FAIL loss_resequence: ready after %0d edges want %0d", n, UP); end
  endtask

  task automatic test_stable_glitch();
    localparam int G = 8;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    for (int e = 1; e <= G + 3 + STB + HOLD; e++) begin
      pll_lock = (e == G) ? 1'b0 : 1'b1;
      tick();
      if (e == G + 2) begin
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL glitch_to_waitlock: state=%0d want 1", state); end
      end
      if (e == G + 3) begin
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL glitch_restable: state=%0d want 2", state); end
      end
      if (e == G + 2 + STB + HOLD) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_early: ready=%b want 0", ready); end
      end
    end
    checks++;
    if (ready !== 1'b1 || lock_loss_cnt !== 8'(exp_loss)) begin
      errors++;
      $display("FAIL glitch_ready: ready=%b loss=%0d want 1/%0d", ready, lock_loss_cnt, exp_loss);
    end
  endtask

  task automatic test_relock_vs_loss();
    int n = 0;
    pll_lock = 1'b0; tick();
    pll_lock = 1'b1; tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    checks++;
    if (state !== 3'd0 || lock_loss_cnt !== 8'(exp_loss) || ready !== 1'b0) begin
      errors++;
      $display("FAIL relock_beats_loss: state=%0d loss=%0d ready=%b want 0/%0d/0", state, lock_loss_cnt, ready, exp_loss);
    end
    while (!ready && n < 200) begin tick(); n++; end
    checks++;
    if (!ready) begin errors++; $display("FAIL relock_recover: ready=%b want 1", ready); end
  endtask

  task automatic test_fail();
    int n = 0;
    relock_req = 1'b1; pll_lock = 1'b0; tick(); relock_req = 1'b0;
    for (int e = 1; e <= 3 * (PRST + TMO); e++) begin
      tick();
      if (e == PRST + TMO || e == 2 * (PRST + TMO)) begin
        checks++;
        if (state !== 3'd0 || retry_cnt !== 3'(e / (PRST + TMO)) || pll_reset !== 1'b1) begin
          errors++;
          $display("FAIL retry_step edge %0d: state=%0d retry=%0d pr=%b want 0/%0d/1",
                   e, state, retry_cnt, pll_reset, e / (PRST + TMO));
        end
      end
      if (e == 3 * (PRST + TMO) - 1) begin
        checks++;
        if (fail !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL fail_early: fail=%b state=%0d want 0/1", fail, state); end
      end
    end
    checks++;
    if (fail !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 3'(MAXR) || state !== 3'd5) begin
      errors++;
      $display("FAIL fail_entry: fail=%b pr=%b retry=%0d state=%0d want 1/1/%0d/5", fail, pll_reset, retry_cnt, state, MAXR);
    end
    pll_lock = 1'b1;
    repeat (20) tick();
    checks++;
    if (fail !== 1'b1 || dsp_reset !== 1'b1) begin errors++; $display("FAIL fail_sticky: fail=%b dsp_reset=%b want 1/1", fail, dsp_reset); end
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    checks++;
    if (fail !== 1'b0 || retry_cnt !== 3'd0 || state !== 3'd0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL fail_clear: fail=%b retry=%0d state=%0d pr=%b want 0/0/0/1", fail, retry_cnt, state, pll_reset);
    end
    while (!ready && n < 200) begin tick(); n++; end
    checks++;
    if (!ready) begin errors++; $display("FAIL fail_recover: ready=%b want 1", ready); end
  endtask

  task automatic test_saturation();
    bit timed_out = 1'b0;
    for (int d = 1; d <= 300; d++) begin
      int n = 0;
      while (!ready && n < 200) begin tick(); n++; end
      if (!ready) timed_out = 1'b1;
      pll_lock = 1'b0; tick(); pll_lock = 1'b1; tick(); tick();
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      if (d == 100) begin
        checks++;
        if (lock_loss_cnt !== 8'(exp_loss)) begin errors++; $display("FAIL loss_count_mid: got %0d want %0d", lock_loss_cnt, exp_loss); end
      end
    end
    checks++;
    if (timed_out) begin errors++; $display("FAIL saturation_wait: ready timed out got 0 want 1"); end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL loss_saturate: got %0d want 255", lock_loss_cnt); end
  endtask

  task automatic test_reset_in_release();
    int n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    for (int e = 1; e <= PRST + 1 + STB + 1; e++) tick();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL reach_release: state=%0d want 3", state); end
    reset = 1'b1; tick();
    exp_loss = 0;
    checks++;
    if ({state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt} !==
        {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_release: state=%0d pr=%b dr=%b rdy=%b fail=%b retry=%0d loss=%0d",
               state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int run = 0, bad = 0;
    logic [16:0] got, exp;
    for (int c = 0; c < 6000; c++) begin
      if (run == 0) begin
        pll_lock = ~pll_lock;
        if (pll_lock) run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 80);
        else          run = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(20, 150);
      end
      run--;
      relock_req = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
      tick();
      got = {state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt};
      exp = {3'(m_st), (m_st == 0 || m_st == 5), (m_st != 4), (m_st == 4), (m_st == 5), 3'(m_retry), 8'(m_loss)};
      checks++;
      if (got !== exp) begin
        errors++;
        if (bad < 20)
          $display("FAIL random cycle %0d: got st=%0d pr=%b dr=%b rdy=%b f=%b retry=%0d loss=%0d want st=%0d retry=%0d loss=%0d",
                   c, state, pll_reset, dsp_reset, ready, fail, retry_cnt, lock_loss_cnt, m_st, m_retry, m_loss);
        bad++;
      end
    end
    relock_req = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock_loss();
    test_stable_glitch();
    test_relock_vs_loss();
    test_fail();
    test_saturation();
    test_reset_in_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
